// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the gate sweep tester: gate function codes, FSM states
// and the largest supported sweep width.
package gate_sweep_pkg;

    localparam int N_MAX = 8;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_NAND = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Codes 6 and 7 have no gate function behind them.
    function automatic logic mode_reserved(input logic [2:0] m);
        return (m > MODE_XNOR);
    endfunction

endpackage

// File: rtl/gate_golden.sv
// Reference gate model: reduces the stimulus vector with the selected gate
// function. Purely combinational.
module gate_golden
    import gate_sweep_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [2:0]   mode,
    input  logic [N-1:0] vec,
    output logic         y
);

    always_comb begin
        y = 1'b0;
        case (mode)
            MODE_AND:  y = &vec;
            MODE_OR:   y = |vec;
            MODE_NAND: y = ~&vec;
            MODE_NOR:  y = ~|vec;
            MODE_XOR:  y = ^vec;
            MODE_XNOR: y = ~^vec;
            default:   y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep.sv
// Exhaustive sweep tester for an external N-input gate; counts response mismatches.
// Optional first-failure capture is enabled by defining GATE_SWEEP_FAIL_CAPTURE_EN.
module gate_sweep
    import gate_sweep_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   mode,
    output logic [N-1:0] vec,
    input  logic         dut_y,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         mode_err,
    output logic [N:0]   err_cnt
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    ,
    output logic [N-1:0] fail_vec,
    output logic         fail_valid
`endif
);

    localparam logic [N:0] ERR_MAX = {1'b1, {N{1'b0}}};

    state_t     state;
    logic [2:0] mode_q;
    logic       golden_y;
    logic       mismatch;
    logic       accept;
    logic [N:0] err_next;

    gate_golden #(.N(N)) u_golden (
        .mode (mode_q),
        .vec  (vec),
        .y    (golden_y)
    );

    assign mismatch = (dut_y != golden_y);
    assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));

    // Saturating count; 2^N is the legitimate all-mismatch total.
    always_comb begin
        err_next = err_cnt;
        if (mismatch && (err_cnt != ERR_MAX))
            err_next = err_cnt + (N+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_AND;
            vec      <= '0;
            err_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            mode_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q  <= mode;
                        vec     <= '0;
                        err_cnt <= '0;
                        pass    <= 1'b0;
                        if (mode_reserved(mode)) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            mode_err <= 1'b1;
                        end else begin
                            state    <= ST_RUN;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            mode_err <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    err_cnt <= err_next;
                    vec     <= vec + N'(1);
                    // Last vector sampled: vec wraps to 0 as the sweep closes.
                    if (&vec) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    vec      <= '0;
                    err_cnt  <= '0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    pass     <= 1'b0;
                    mode_err <= 1'b0;
                end
            endcase
        end
    end

`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    // Only the first mismatching vector of a sweep is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else if (accept) begin
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else if ((state == ST_RUN) && mismatch && !fail_valid) begin
            fail_vec   <= vec;
            fail_valid <= 1'b1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gate_sweep.sv
// Directed bench for gate_sweep: an N=3 and an N=4 instance driven by a
// behavioural gate with selectable faults.
module tb_gate_sweep;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         errors = 0;

    logic       start_a, start_b;
    logic [2:0] mode_a, mode_b;
    logic [2:0] vec_a;
    logic [3:0] vec_b;
    logic       dut_y_a, dut_y_b;
    logic       busy_a, done_a, pass_a, mode_err_a;
    logic       busy_b, done_b, pass_b, mode_err_b;
    logic [3:0] err_cnt_a;
    logic [4:0] err_cnt_b;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    logic [2:0] fail_vec_a;
    logic [3:0] fail_vec_b;
    logic       fail_valid_a, fail_valid_b;
`endif

    // kind: gate function code; fault: 0 ideal, 1 stuck at 1, 2 inverted
    int kind_a = 0, fault_a = 0, kind_b = 0, fault_b = 0;

    always #5 clk = ~clk;

    function automatic logic gate_model(input int kind, input int fault,
                                        input logic [7:0] v, input int n);
        logic a, o, x, y;
        a = 1'b1; o = 1'b0; x = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = a & v[i];
            o = o | v[i];
            x = x ^ v[i];
        end
        case (kind)
            0: y = a;
            1: y = o;
            2: y = ~a;
            3: y = ~o;
            4: y = x;
            default: y = ~x;
        endcase
        if (fault == 1) y = 1'b1;
        else if (fault == 2) y = ~y;
        return y;
    endfunction

    always_comb dut_y_a = gate_model(kind_a, fault_a, {5'b0, vec_a}, 3);
    always_comb dut_y_b = gate_model(kind_b, fault_b, {4'b0, vec_b}, 4);

    gate_sweep #(.N(3)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_a),
        .mode     (mode_a),
        .vec      (vec_a),
        .dut_y    (dut_y_a),
        .busy     (busy_a),
        .done     (done_a),
        .pass     (pass_a),
        .mode_err (mode_err_a),
        .err_cnt  (err_cnt_a)
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        ,
        .fail_vec   (fail_vec_a),
        .fail_valid (fail_valid_a)
`endif
    );

    gate_sweep #(.N(4)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_b),
        .mode     (mode_b),
        .vec      (vec_b),
        .dut_y    (dut_y_b),
        .busy     (busy_b),
        .done     (done_b),
        .pass     (pass_b),
        .mode_err (mode_err_b),
        .err_cnt  (err_cnt_b)
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        ,
        .fail_vec   (fail_vec_b),
        .fail_valid (fail_valid_b)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode_a = 3'd0; mode_b = 3'd0;
        #3;
        checks++;
        if ({vec_a, err_cnt_a, busy_a, done_a, pass_a, mode_err_a} !== 11'd0) begin
            errors++;
            $display("FAIL reset_a: got %h expected 0", {vec_a, err_cnt_a, busy_a, done_a, pass_a, mode_err_a});
        end
        checks++;
        if ({vec_b, err_cnt_b, busy_b, done_b, pass_b, mode_err_b} !== 13'd0) begin
            errors++;
            $display("FAIL reset_b: got %h expected 0", {vec_b, err_cnt_b, busy_b, done_b, pass_b, mode_err_b});
        end
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        checks++;
        if ({fail_vec_a, fail_valid_a} !== 4'd0) begin
            errors++;
            $display("FAIL reset_fail_a: got %h expected 0", {fail_vec_a, fail_valid_a});
        end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_nand_ideal();
        kind_a = 2; fault_a = 0; mode_a = 3'd2; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy_a !== 1'b1 || vec_a !== i[2:0]) begin
                errors++;
                $display("FAIL nand_step%0d: got busy=%b vec=%0d expected busy=1 vec=%0d", i, busy_a, vec_a, i);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({done_a, pass_a, busy_a, mode_err_a} !== 4'b1100) begin
            errors++;
            $display("FAIL nand_flags: got done,pass,busy,mode_err=%b expected 1100", {done_a, pass_a, busy_a, mode_err_a});
        end
        checks++;
        if (err_cnt_a !== 4'd0 || vec_a !== 3'd0) begin
            errors++;
            $display("FAIL nand_count: got err_cnt=%0d vec=%0d expected 0 0", err_cnt_a, vec_a);
        end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (done_a !== 1'b1 || pass_a !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: got done=%b pass=%b expected 1 1", done_a, pass_a);
        end
    endtask

    task automatic test_stuck_one();
        int n;
        kind_a = 2; fault_a = 1; mode_a = 3'd2; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        checks++;
        if ({done_a, pass_a, busy_a} !== 3'b001 || err_cnt_a !== 4'd0) begin
            errors++;
            $display("FAIL restart_clear: got done,pass,busy=%b err_cnt=%0d expected 001 0", {done_a, pass_a, busy_a}, err_cnt_a);
        end
        n = 0;
        while (!done_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL stuck_timeout: got no done after %0d cycles expected done", n);
        end
        checks++;
        if (err_cnt_a !== 4'd1 || pass_a !== 1'b0) begin
            errors++;
            $display("FAIL stuck_result: got err_cnt=%0d pass=%b expected 1 0", err_cnt_a, pass_a);
        end
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        checks++;
        if (fail_vec_a !== 3'b111 || fail_valid_a !== 1'b1) begin
            errors++;
            $display("FAIL stuck_capture: got fail_vec=%b valid=%b expected 111 1", fail_vec_a, fail_valid_a);
        end
`endif
        fault_a = 0;
    endtask

    task automatic test_parity_n4();
        int cycles, guard;
        kind_b = 4; fault_b = 2; mode_b = 3'd4; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cycles = 0; guard = 0;
        while (!done_b && guard < 40) begin
            if (busy_b) cycles++;
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (cycles !== 16 || done_b !== 1'b1) begin
            errors++;
            $display("FAIL n4_length: got busy cycles=%0d done=%b expected 16 1", cycles, done_b);
        end
        checks++;
        if (err_cnt_b !== 5'd16 || pass_b !== 1'b0) begin
            errors++;
            $display("FAIL n4_saturate: got err_cnt=%0d pass=%b expected 16 0", err_cnt_b, pass_b);
        end
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        checks++;
        if (fail_vec_b !== 4'd0 || fail_valid_b !== 1'b1) begin
            errors++;
            $display("FAIL n4_first_fail: got fail_vec=%0d valid=%b expected 0 1", fail_vec_b, fail_valid_b);
        end
`endif
    endtask

    task automatic test_start_ignored();
        int n;
        kind_a = 0; fault_a = 0; mode_a = 3'd0; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        checks++;
        if (fail_valid_a !== 1'b0 || fail_vec_a !== 3'd0) begin
            errors++;
            $display("FAIL capture_clear: got fail_vec=%b valid=%b expected 000 0", fail_vec_a, fail_valid_a);
        end
`endif
        repeat (2) @(posedge clk); #1;
        start_a = 1'b1; mode_a = 3'd1;
        @(posedge clk); #1;
        start_a = 1'b0;
        checks++;
        if (vec_a !== 3'd3 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL no_restart: got vec=%0d busy=%b expected 3 1", vec_a, busy_a);
        end
        n = 0;
        while (!done_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done_a !== 1'b1 || pass_a !== 1'b1 || err_cnt_a !== 4'd0) begin
            errors++;
            $display("FAIL mode_kept: got done=%b pass=%b err_cnt=%0d expected 1 1 0", done_a, pass_a, err_cnt_a);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        kind_a = 0; fault_a = 2; mode_a = 3'd0; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (5) @(posedge clk); #1;
        checks++;
        if (vec_a !== 3'd5 || err_cnt_a !== 4'd5) begin
            errors++;
            $display("FAIL pre_abort: got vec=%0d err_cnt=%0d expected 5 5", vec_a, err_cnt_a);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({vec_a, err_cnt_a, busy_a, done_a, pass_a, mode_err_a} !== 11'd0) begin
            errors++;
            $display("FAIL async_abort: got %h expected 0", {vec_a, err_cnt_a, busy_a, done_a, pass_a, mode_err_a});
        end
        fault_a = 0; start_a = 1'b1; mode_a = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || vec_a !== 3'd0) begin
            errors++;
            $display("FAIL first_start: got busy=%b vec=%0d expected 1 0", busy_a, vec_a);
        end
        n = 0;
        while (!done_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 8 || pass_a !== 1'b1 || err_cnt_a !== 4'd0) begin
            errors++;
            $display("FAIL fresh_sweep: got cycles=%0d pass=%b err_cnt=%0d expected 8 1 0", n, pass_a, err_cnt_a);
        end
    endtask

    task automatic test_reserved();
        int busy_seen;
        mode_a = 3'd6; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        busy_seen = busy_a;
        checks++;
        if ({done_a, mode_err_a, pass_a} !== 3'b110 || err_cnt_a !== 4'd0) begin
            errors++;
            $display("FAIL reserved: got done,mode_err,pass=%b err_cnt=%0d expected 110 0", {done_a, mode_err_a, pass_a}, err_cnt_a);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy_a) busy_seen = 1;
        end
        checks++;
        if (busy_seen !== 0 || done_a !== 1'b1 || mode_err_a !== 1'b1) begin
            errors++;
            $display("FAIL reserved_hold: got busy_seen=%0d done=%b mode_err=%b expected 0 1 1", busy_seen, done_a, mode_err_a);
        end
    endtask

    task automatic test_restart_from_done();
        int cycles, guard;
        kind_a = 0; fault_a = 0; mode_a = 3'd0; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        checks++;
        if ({done_a, mode_err_a, pass_a, busy_a} !== 4'b0001 || err_cnt_a !== 4'd0) begin
            errors++;
            $display("FAIL restart_flags: got done,mode_err,pass,busy=%b err_cnt=%0d expected 0001 0", {done_a, mode_err_a, pass_a, busy_a}, err_cnt_a);
        end
        cycles = 0; guard = 0;
        while (!done_a && guard < 20) begin
            if (busy_a) cycles++;
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (cycles !== 8 || pass_a !== 1'b1 || err_cnt_a !== 4'd0) begin
            errors++;
            $display("FAIL restart_sweep: got cycles=%0d pass=%b err_cnt=%0d expected 8 1 0", cycles, pass_a, err_cnt_a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_nand_ideal();
        test_stuck_one();
        test_parity_n4();
        test_start_ignored();
        test_reset_mid_run();
        test_reserved();
        test_restart_from_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
